// File: rtl/fee_payment.sv
// Parking fee payment: converts elapsed time to a charge, takes coins, returns change, opens the gate.
// Optional build macro FEE_CAP_EN clamps every charge to MAX_CHARGE.
module fee_payment #(
    parameter int TIME_W      = 11,
    parameter int AMT_W       = 16,
    parameter int FREE_UNITS  = 2,
    parameter int RATE        = 5,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int MAX_CHARGE  = 500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fee_valid,
    input  logic [TIME_W-1:0] use_time,
    input  logic              coin_valid,
    input  logic [1:0]        coin_code,
    input  logic              cancel,
    output logic              busy,
    output logic [AMT_W-1:0]  amount_due,
    output logic [AMT_W-1:0]  paid_total,
    output logic              change_valid,
    output logic [AMT_W-1:0]  change_amount,
    output logic              gate_open,
    output logic              coin_reject,
    output logic              fee_drop
);

    typedef enum logic [2:0] {IDLE, CALC, WAIT_PAY, CHANGE, REFUND, DONE} state_t;

    localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int               PROD_W    = AMT_W + TIME_W;
    localparam logic [AMT_W-1:0] AMT_MAX   = '1;
    localparam logic [15:0]      COIN_VALS = {4'd10, 4'd5, 4'd2, 4'd1};

    if ((MAX_CHARGE < 0) || (TIMEOUT_CYC < 1)) begin : g_bad_params
        $error("fee_payment: MAX_CHARGE must be >= 0 and TIMEOUT_CYC >= 1");
    end

    state_t            state_reg, state_next;
    logic [TIME_W-1:0] use_time_reg, use_time_next;
    logic [AMT_W-1:0]  charge_reg, charge_next;
    logic [AMT_W-1:0]  paid_reg, paid_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [AMT_W-1:0]  change_amount_reg, change_amount_next;
    logic              change_valid_reg, change_valid_next;
    logic              gate_open_reg, gate_open_next;
    logic              coin_reject_reg, coin_reject_next;
    logic              fee_drop_reg, fee_drop_next;

    logic [AMT_W-1:0]  coin_lut [4];
    logic [AMT_W-1:0]  coin_value;
    logic [AMT_W:0]    paid_sum;
    logic [AMT_W-1:0]  paid_sat;
    logic [TIME_W-1:0] billable;
    logic [PROD_W-1:0] product;
    logic [AMT_W-1:0]  charge_sat;
    logic [AMT_W-1:0]  charge_calc;

    for (genvar gi = 0; gi < 4; gi++) begin : g_coin_lut
        assign coin_lut[gi] = AMT_W'(COIN_VALS[gi*4 +: 4]);
    end

    assign coin_value = coin_lut[coin_code];
    assign paid_sum   = {1'b0, paid_reg} + {1'b0, coin_value};
    assign paid_sat   = paid_sum[AMT_W] ? AMT_MAX : paid_sum[AMT_W-1:0];

    // Product is formed wide enough that it can never wrap before saturation.
    assign billable   = (use_time_reg <= TIME_W'(FREE_UNITS)) ? '0
                                                              : use_time_reg - TIME_W'(FREE_UNITS);
    assign product    = PROD_W'(billable) * PROD_W'(RATE);
    assign charge_sat = (product > PROD_W'(AMT_MAX)) ? AMT_MAX : product[AMT_W-1:0];

`ifdef FEE_CAP_EN
    assign charge_calc = (charge_sat > AMT_W'(MAX_CHARGE)) ? AMT_W'(MAX_CHARGE) : charge_sat;
`else
    assign charge_calc = charge_sat;
`endif

    always_comb begin
        state_next         = state_reg;
        use_time_next      = use_time_reg;
        charge_next        = charge_reg;
        paid_next          = paid_reg;
        cnt_next           = cnt_reg;
        change_amount_next = change_amount_reg;
        change_valid_next  = 1'b0;
        gate_open_next     = 1'b0;
        coin_reject_next   = coin_valid;
        fee_drop_next      = fee_valid && (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (fee_valid) begin
                    use_time_next = use_time;
                    paid_next     = '0;
                    state_next    = CALC;
                end
            end
            CALC: begin
                charge_next = charge_calc;
                cnt_next    = '0;
                if (charge_calc == '0) begin
                    state_next     = DONE;
                    gate_open_next = 1'b1;
                end else begin
                    state_next = WAIT_PAY;
                end
            end
            WAIT_PAY: begin
                // Priority: cancel, then completed payment, then coin, then timeout.
                if (cancel) begin
                    state_next         = REFUND;
                    change_valid_next  = 1'b1;
                    change_amount_next = paid_reg;
                end else if (paid_reg >= charge_reg) begin
                    state_next         = CHANGE;
                    change_valid_next  = 1'b1;
                    change_amount_next = paid_reg - charge_reg;
                end else if (coin_valid) begin
                    coin_reject_next = 1'b0;
                    paid_next        = paid_sat;
                    cnt_next         = '0;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_next         = REFUND;
                    change_valid_next  = 1'b1;
                    change_amount_next = paid_reg;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            CHANGE: begin
                state_next     = DONE;
                gate_open_next = 1'b1;
            end
            REFUND:  state_next = IDLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            use_time_reg      <= '0;
            charge_reg        <= '0;
            paid_reg          <= '0;
            cnt_reg           <= '0;
            change_amount_reg <= '0;
            change_valid_reg  <= 1'b0;
            gate_open_reg     <= 1'b0;
            coin_reject_reg   <= 1'b0;
            fee_drop_reg      <= 1'b0;
        end else begin
            state_reg         <= state_next;
            use_time_reg      <= use_time_next;
            charge_reg        <= charge_next;
            paid_reg          <= paid_next;
            cnt_reg           <= cnt_next;
            change_amount_reg <= change_amount_next;
            change_valid_reg  <= change_valid_next;
            gate_open_reg     <= gate_open_next;
            coin_reject_reg   <= coin_reject_next;
            fee_drop_reg      <= fee_drop_next;
        end
    end

    assign busy          = (state_reg != IDLE);
    assign amount_due    = ((state_reg == WAIT_PAY) && (charge_reg > paid_reg)) ? charge_reg - paid_reg : '0;
    assign paid_total    = paid_reg;
    assign change_valid  = change_valid_reg;
    assign change_amount = change_amount_reg;
    assign gate_open     = gate_open_reg;
    assign coin_reject   = coin_reject_reg;
    assign fee_drop      = fee_drop_reg;

endmodule

// File: tb/tb_fee_payment.sv
// Self-checking bench for fee_payment: vector table plus corner-case sequences, with a
// scoreboard queue of expected change/gate events checked by a negedge monitor.
module tb_fee_payment;

    localparam int TIME_W = 11;
    localparam int AMT_W  = 16;
`ifdef FEE_CAP_EN
    localparam int BIG_CHARGE = 500;
`else
    localparam int BIG_CHARGE = 10225;
`endif

    logic              clk;
    logic              reset;
    logic              fee_valid;
    logic [TIME_W-1:0] use_time;
    logic              coin_valid;
    logic [1:0]        coin_code;
    logic              cancel;
    logic              busy;
    logic [AMT_W-1:0]  amount_due;
    logic [AMT_W-1:0]  paid_total;
    logic              change_valid;
    logic [AMT_W-1:0]  change_amount;
    logic              gate_open;
    logic              coin_reject;
    logic              fee_drop;

    fee_payment #(.TIMEOUT_CYC(20)) dut (
        .clk(clk), .reset(reset), .fee_valid(fee_valid), .use_time(use_time),
        .coin_valid(coin_valid), .coin_code(coin_code), .cancel(cancel),
        .busy(busy), .amount_due(amount_due), .paid_total(paid_total),
        .change_valid(change_valid), .change_amount(change_amount),
        .gate_open(gate_open), .coin_reject(coin_reject), .fee_drop(fee_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;      // 0 = change/refund pulse, 1 = gate_open pulse
        int amount;
    } ev_t;

    typedef struct {
        int         use_time;
        int         ncoins;
        logic [5:0] codes;   // coin i in codes[2*i +: 2]
        int         charge;
        int         change;
    } vec_t;

    ev_t  sb[$];
    ev_t  mon_ev;
    vec_t vecs[7];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic int coin_val(input int code);
        case (code)
            0: return 1;
            1: return 2;
            2: return 5;
            default: return 10;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fee(input int ut);
        fee_valid = 1'b1;
        use_time  = TIME_W'(ut);
        tick();
        fee_valid = 1'b0;
    endtask

    task automatic coin(input int code);
        coin_valid = 1'b1;
        coin_code  = 2'(code);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic expect_ev(input int kind, input int amt);
        ev_t e;
        e.kind   = kind;
        e.amount = amt;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        check(name, int'(busy), 0);
    endtask

    always @(negedge clk) begin
        if (change_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_change: got change_amount %0d, required no pulse", change_amount);
            end else begin
                mon_ev = sb.pop_front();
                check("event_is_change", 0, mon_ev.kind);
                check("change_amount", int'(change_amount), mon_ev.amount);
            end
        end
        if (gate_open) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_gate: got gate_open 1, required no pulse");
            end else begin
                mon_ev = sb.pop_front();
                check("event_is_gate", 1, mon_ev.kind);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int paid;
        int code;
        int due;

        vecs[0] = '{2,  0, 6'b000000,            0,  0};
        vecs[1] = '{4,  1, {2'd0, 2'd0, 2'd3},   10, 0};
        vecs[2] = '{5,  2, {2'd0, 2'd3, 2'd3},   15, 5};
        vecs[3] = '{0,  0, 6'b000000,            0,  0};
        vecs[4] = '{3,  1, {2'd0, 2'd0, 2'd2},   5,  0};
        vecs[5] = '{7,  3, {2'd3, 2'd3, 2'd3},   25, 5};
        vecs[6] = '{6,  2, {2'd0, 2'd3, 2'd3},   20, 0};

        reset = 1'b1; fee_valid = 1'b0; use_time = '0;
        coin_valid = 1'b0; coin_code = '0; cancel = 1'b0;
        repeat (3) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_amount_due", int'(amount_due), 0);
        check("reset_paid_total", int'(paid_total), 0);
        check("reset_change_amount", int'(change_amount), 0);
        check("reset_pulses", int'({change_valid, gate_open, coin_reject, fee_drop}), 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            paid = 0;
            fee(vecs[v].use_time);
            check("busy_in_calc", int'(busy), 1);
            if (vecs[v].charge == 0) expect_ev(1, 0);
            tick();
            if (vecs[v].charge > 0) begin
                check("amount_due_start", int'(amount_due), vecs[v].charge);
                for (int i = 0; i < vecs[v].ncoins; i++) begin
                    code = int'(vecs[v].codes[2*i +: 2]);
                    paid += coin_val(code);
                    if (paid >= vecs[v].charge) begin
                        expect_ev(0, paid - vecs[v].charge);
                        expect_ev(1, 0);
                    end
                    coin(code);
                    due = (paid >= vecs[v].charge) ? 0 : vecs[v].charge - paid;
                    check("paid_after_coin", int'(paid_total), paid);
                    check("amount_due_after_coin", int'(amount_due), due);
                    tick();
                end
            end else begin
                check("amount_due_free", int'(amount_due), 0);
            end
            wait_idle("txn_returns_idle");
            check("paid_final", int'(paid_total), paid);
            $display("txn %0d: use_time=%0d charge=%0d paid=%0d", v, vecs[v].use_time, vecs[v].charge, paid);
        end

        // Coin while idle is rejected.
        coin(3);
        check("idle_coin_reject", int'(coin_reject), 1);
        tick();
        check("idle_coin_reject_clears", int'(coin_reject), 0);
        $display("txn idle coin: rejected");

        // Overpayment, then a coin during CHANGE.
        fee(5); tick();
        coin(3);
        check("overpay_due_5", int'(amount_due), 5);
        tick();
        expect_ev(0, 5); expect_ev(1, 0);
        coin(3);
        check("overpay_due_0", int'(amount_due), 0);
        tick();
        coin(3);
        check("change_state_coin_reject", int'(coin_reject), 1);
        check("change_state_paid", int'(paid_total), 20);
        wait_idle("overpay_idle");
        $display("txn overpay: paid=20 change=5");

        // Inactivity timeout refund.
        fee(3); tick();
        coin(1);
        expect_ev(0, 2);
        repeat (19) tick();
        check("timeout_still_waiting", int'(amount_due), 3);
        check("timeout_no_early_refund", int'(change_valid), 0);
        tick();
        check("timeout_refund_pulse", int'(change_valid), 1);
        tick();
        check("timeout_idle", int'(busy), 0);
        $display("txn timeout: refund=2");

        // Coin on the expiry cycle wins over the timeout.
        fee(3); tick();
        coin(1);
        repeat (19) tick();
        coin(1);
        check("expiry_coin_paid", int'(paid_total), 4);
        check("expiry_coin_busy", int'(busy), 1);
        check("expiry_coin_no_refund", int'(change_valid), 0);
        repeat (19) tick();
        check("expiry_coin_due", int'(amount_due), 1);
        expect_ev(0, 0); expect_ev(1, 0);
        coin(0);
        tick();
        wait_idle("expiry_coin_idle");
        $display("txn expiry coin: paid=5 change=0");

        // fee_valid while busy is dropped.
        fee(4); tick();
        fee(100);
        check("fee_drop_pulse", int'(fee_drop), 1);
        check("fee_drop_charge_kept", int'(amount_due), 10);
        tick();
        check("fee_drop_one_cycle", int'(fee_drop), 0);
        expect_ev(0, 0); expect_ev(1, 0);
        coin(3);
        tick();
        wait_idle("fee_drop_idle");
        $display("txn fee drop: charge=10 kept");

        // Cancel together with a coin: coin rejected, refund of 7.
        fee(10); tick();
        coin(2);
        coin(1);
        expect_ev(0, 7);
        coin_valid = 1'b1; coin_code = 2'd0; cancel = 1'b1;
        tick();
        coin_valid = 1'b0; cancel = 1'b0;
        check("cancel_coin_reject", int'(coin_reject), 1);
        check("cancel_paid", int'(paid_total), 7);
        tick();
        check("cancel_busy_low", int'(busy), 0);
        check("cancel_no_gate", int'(gate_open), 0);
        $display("txn cancel: refund=7");

        // Maximum use_time, then reset in WAIT_PAY.
        fee(2047); tick();
        check("big_charge", int'(amount_due), BIG_CHARGE);
        coin(3);
        check("big_paid", int'(paid_total), 10);
        check("held_change_amount", int'(change_amount), 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_busy", int'(busy), 0);
        check("midreset_amount_due", int'(amount_due), 0);
        check("midreset_paid", int'(paid_total), 0);
        check("midreset_change_amount", int'(change_amount), 0);
        check("midreset_pulses", int'({change_valid, gate_open, coin_reject, fee_drop}), 0);
        $display("txn big charge + reset: charge=%0d", BIG_CHARGE);

        repeat (5) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fee_payment.md
Name: fee_payment

Overview:
- Downstream of the check-in/out stage; consumes the elapsed-time value produced at check-out.
- Converts elapsed time to a charge, collects coins, returns change, then pulses gate_open.
- On cancel or inactivity timeout, refunds all inserted coins and does not open the gate.
- One transaction at a time, driven by a single FSM.

Parameters:
- TIME_W, 11: width of the elapsed-time input.
- AMT_W, 16: width of all money values.
- FREE_UNITS, 2: grace period in time units; this many units are free of charge.
- RATE, 5: credits charged per time unit beyond FREE_UNITS.
- TIMEOUT_CYC, 50000000: number of idle cycles in WAIT_PAY before an automatic refund.
- MAX_CHARGE, 500: charge ceiling, used only when FEE_CAP_EN is defined.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- fee_valid, input, 1: one-cycle pulse; use_time is valid in that cycle.
- use_time, input, TIME_W: elapsed time in units, unsigned.
- coin_valid, input, 1: one-cycle pulse; one coin inserted.
- coin_code, input, 2: coin value encoding, 0=1, 1=2, 2=5, 3=10 credits.
- cancel, input, 1: user abort request; acted on in WAIT_PAY only.
- busy, output, 1: high in every state except IDLE.
- amount_due, output, AMT_W: charge minus paid_total while in WAIT_PAY, otherwise 0.
- paid_total, output, AMT_W: credits accumulated in the current transaction.
- change_valid, output, 1: one-cycle pulse; change_amount is valid in that cycle.
- change_amount, output, AMT_W: change or refund value; held until the next change_valid.
- gate_open, output, 1: one-cycle pulse when payment is complete.
- coin_reject, output, 1: one-cycle pulse; the coin in that cycle was returned, not counted.
- fee_drop, output, 1: one-cycle pulse; fee_valid arrived while busy and was ignored.

Behaviour:
- Reset: state=IDLE. All outputs are 0. Internal charge, paid_total and timeout counter are cleared. Reset aborts any transaction, with no refund pulse.
- FSM states: IDLE, CALC, WAIT_PAY, CHANGE, REFUND, DONE.
- IDLE:
  - fee_valid latches use_time and moves to CALC.
  - paid_total is cleared on that transition.
  - coin_valid in IDLE → coin_reject.
- CALC (1 cycle):
  - charge = (use_time <= FREE_UNITS) ? 0 : (use_time - FREE_UNITS) * RATE.
  - The product is computed at AMT_W+TIME_W bits, then saturated to 2^AMT_W-1.
  - charge==0 → DONE. Otherwise → WAIT_PAY, with the timeout counter cleared.
- WAIT_PAY:
  - coin_valid adds the decoded value to paid_total, saturating at 2^AMT_W-1. It also clears the timeout counter.
  - Once the registered paid_total >= charge → CHANGE on the next cycle. Latency from the completing coin to change_valid is 2 cycles.
  - cancel → REFUND. If coin_valid and cancel occur in the same cycle, cancel wins: the coin gets coin_reject and is not added.
  - When the counter reaches TIMEOUT_CYC-1 with no coin that cycle → REFUND. A coin in the expiry cycle is counted and the counter restarts (coin wins).
- CHANGE (1 cycle): change_amount = paid_total - charge, change_valid=1 (even when change is 0) → DONE.
- REFUND (1 cycle): change_amount = paid_total, change_valid=1 → IDLE, with no gate_open. A refund of 0 still pulses change_valid.
- DONE (1 cycle): gate_open=1 → IDLE.
- Coin handling outside WAIT_PAY: coin_valid in CALC, CHANGE, REFUND or DONE → coin_reject, paid_total unchanged.
- fee_valid in any state other than IDLE → fee_drop. The in-flight transaction is unaffected.
- Pulse outputs (change_valid, gate_open, coin_reject, fee_drop) are registered and never high for more than 1 cycle per event.

Optional Feature:
- Macro: FEE_CAP_EN.
- Defined: after the saturation step in CALC, charge = min(charge, MAX_CHARGE).
- Undefined: only the 2^AMT_W-1 saturation applies, and MAX_CHARGE is unused.

Test Plan (defaults except TIMEOUT_CYC=20):
- Grace period: fee_valid, use_time=2 → CALC → DONE. gate_open pulses 2 cycles after fee_valid. change_valid never pulses; paid_total=0.
- Exact payment: use_time=4 (charge 10), one coin_code=3 → paid_total=10, change_valid with change_amount=0, then gate_open the following cycle.
- Overpayment: use_time=5 (charge 15). Coins 10, 10 → amount_due 15→5→0, change_amount=5, gate_open=1. A coin during CHANGE → coin_reject.
- Cancel: use_time=10 (charge 40). Coins 5, 2, then coin_code=0 with cancel in the same cycle → coin_reject=1, change_amount=7, no gate_open, busy low the next cycle.
- Timeout: use_time=3 (charge 5). One coin of 2, then 20 idle cycles → REFUND, change_amount=2. Repeat with a coin landing on cycle 19 → payment continues, no refund.
- Busy and cap:
  - fee_valid during WAIT_PAY → fee_drop, charge unchanged.
  - With FEE_CAP_EN, use_time=2047 → amount_due=500.
  - Without FEE_CAP_EN, use_time=2047 → amount_due=10225.
  - reset mid-WAIT_PAY → all outputs 0, state IDLE.
